aquarium_scan_sequencer: RTL and testbench



---
 rtl/aquarium_scan_sequencer.sv | 86 ++++++++
 tb/tb_aquarium_scan_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/aquarium_scan_sequencer.sv
// aquarium_scan_sequencer: steps the display-mux select through the counter and tank-register slots,
// range-checks each register while shown and holds the mux in error mode until a fault is acknowledged.
module aquarium_scan_sequencer #(
    parameter int         DWELL     = 4,
    parameter logic [7:0] CLEAN_MIN = 8'd32,
    parameter logic [7:0] TEMP_MIN  = 8'd20,
    parameter logic [7:0] TEMP_MAX  = 8'd30,
    parameter logic [7:0] FOOD_MIN  = 8'd16,
    parameter logic [7:0] SALT_MIN  = 8'd30,
    parameter logic [7:0] SALT_MAX  = 8'd40
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       enable,
    input  logic       ack,
    input  logic [7:0] Q_tank_cleanliness,
    input  logic [7:0] Q_tank_temperature,
    input  logic [7:0] Q_tank_food_storage,
    input  logic [7:0] Q_tank_saltiness,
    output logic [4:0] select,
    output logic [7:0] counter,
    output logic [3:0] fault_flags,
    output logic       error,
    output logic       scan_done
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_CLEAN = 3'd2;
    localparam logic [2:0] S_TEMP  = 3'd3;
    localparam logic [2:0] S_FOOD  = 3'd4;
    localparam logic [2:0] S_SALT  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;
    localparam logic [7:0] LAST    = 8'(DWELL - 1);

    logic [2:0] r_state;
    logic [7:0] r_dwell;
    logic [2:0] w_next;
    logic       w_last;
    logic       w_salt_exit;
    logic [3:0] w_check;
    logic [3:0] w_flags;
    logic [4:0] w_sel;

    always_comb begin
        w_last      = r_dwell == LAST;
        w_salt_exit = r_state == S_SALT && w_last;
        // each check only counts on the final dwell cycle of its own slot
        w_check     = {4{w_last}} & {
            r_state == S_SALT  && (Q_tank_saltiness < SALT_MIN || Q_tank_saltiness > SALT_MAX),
            r_state == S_FOOD  && Q_tank_food_storage < FOOD_MIN,
            r_state == S_TEMP  && (Q_tank_temperature < TEMP_MIN || Q_tank_temperature > TEMP_MAX),
            r_state == S_CLEAN && Q_tank_cleanliness < CLEAN_MIN};
        w_flags     = fault_flags | w_check;
        w_next      = r_state == S_IDLE  ? (enable ? S_COUNT : S_IDLE) :
                      r_state == S_ERROR ? (ack ? S_COUNT : S_ERROR) :
                      !w_last            ? r_state :
                      r_state == S_SALT  ? (|w_flags ? S_ERROR : enable ? S_COUNT : S_IDLE) :
                      r_state + 3'd1;
        w_sel       = w_next == S_COUNT ? 5'b00001 :
                      w_next == S_CLEAN ? 5'b00010 :
                      w_next == S_TEMP  ? 5'b00100 :
                      w_next == S_FOOD  ? 5'b01000 :
                      w_next == S_SALT  ? 5'b10000 :
                      w_next == S_ERROR ? 5'b11111 : 5'b00000;
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_dwell     <= '0;
            select      <= '0;
            counter     <= '0;
            fault_flags <= '0;
            error       <= 1'b0;
            scan_done   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_dwell     <= (w_next != r_state || w_next == S_IDLE || w_next == S_ERROR) ? '0 : r_dwell + 8'd1;
            select      <= w_sel;
            counter     <= counter + {7'd0, w_salt_exit};
            fault_flags <= (w_next == S_COUNT && r_state != S_COUNT) ? '0 : w_flags;
            error       <= w_next == S_ERROR;
            scan_done   <= w_salt_exit;
        end
    end
endmodule

// File: tb/tb_aquarium_scan_sequencer.sv
// tb_aquarium_scan_sequencer: scan-level reference model pushes per-cycle expectations;
// a negedge monitor pops and compares them against whichever instance is active.
module tb_aquarium_scan_sequencer;
    logic       CLK = 1'b0;
    logic       rst0, rst1, enable, ack;
    logic [7:0] q_cl, q_te, q_fo, q_sa;
    logic [4:0] sel0, sel1;
    logic [7:0] cn0, cn1;
    logic [3:0] fl0, fl1;
    logic       er0, er1, dn0, dn1;

    aquarium_scan_sequencer #(.DWELL(4)) dut0 (
        .CLK(CLK), .reset(rst0), .enable(enable), .ack(ack),
        .Q_tank_cleanliness(q_cl), .Q_tank_temperature(q_te),
        .Q_tank_food_storage(q_fo), .Q_tank_saltiness(q_sa),
        .select(sel0), .counter(cn0), .fault_flags(fl0), .error(er0), .scan_done(dn0));

    aquarium_scan_sequencer #(.DWELL(1)) dut1 (
        .CLK(CLK), .reset(rst1), .enable(enable), .ack(ack),
        .Q_tank_cleanliness(q_cl), .Q_tank_temperature(q_te),
        .Q_tank_food_storage(q_fo), .Q_tank_saltiness(q_sa),
        .select(sel1), .counter(cn1), .fault_flags(fl1), .error(er1), .scan_done(dn1));

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [4:0] sel;
        logic [3:0] fl;
        logic [7:0] cn;
        logic       er;
        logic       dn;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    bit         dut = 0;
    int         D = 4;
    logic [7:0] cnt = 0;
    int         mode = 0;
    logic [3:0] last_f = 0;
    int         err_hold = 2;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin : mon
        exp_t       e;
        logic [18:0] got, want;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e    = q.pop_front();
            got  = dut ? {sel1, fl1, cn1, er1, dn1} : {sel0, fl0, cn0, er0, dn0};
            want = {e.sel, e.fl, e.cn, e.er, e.dn};
            total++;
            if (e.cyc != cyc || got !== want) begin
                bad++;
                $display("FAIL cyc%0d dut%0d got sel=%b flags=%b cnt=%0d err=%b done=%b want sel=%b flags=%b cnt=%0d err=%b done=%b (exp cyc %0d)",
                         cyc, dut, got[18:14], got[13:10], got[9:2], got[1], got[0],
                         e.sel, e.fl, e.cn, e.er, e.dn, e.cyc);
            end
        end
    end

    function automatic void push(int c, logic [4:0] s, logic [3:0] f, logic [7:0] n, logic e, logic d);
        q.push_back('{c, s, f, n, e, d});
    endfunction

    function automatic logic [7:0] pick(logic [7:0] nom);
        return $urandom_range(0, 1) ? nom : 8'($urandom_range(0, 60));
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_rst(logic v);
        if (dut) rst1 = v;
        else rst0 = v;
    endtask

    // one full scan: entry from the current mode, slot timeline, then the outcome cycle
    task automatic scan(input logic [7:0] cl, te, fo, sa, input bit en_after, input int rst_k);
        bit         done0;
        logic [3:0] f, fk;
        int         c0, drop;
        done0 = mode == 1;
        if (mode == 0) begin
            repeat ($urandom_range(0, 3)) begin
                enable = 0;
                ack = 1'($urandom);
                push(cyc + 1, 5'b0, 4'b0, cnt, 0, 0);
                tick();
            end
            enable = 1;
            tick();
        end else if (mode == 2) begin
            ack = 0;
            repeat (err_hold) begin
                enable = 1'($urandom);
                push(cyc + 1, 5'b11111, last_f, cnt, 1, 0);
                tick();
            end
            ack = 1;
            tick();
            ack = 0;
        end
        c0 = cyc;
        enable = 1;
        q_cl = cl; q_te = te; q_fo = fo; q_sa = sa;
        f = {sa < 30 || sa > 40, fo < 16, te < 20 || te > 30, cl < 32};
        drop = en_after ? -1 : 2 * D + $urandom_range(0, D - 1);
        for (int k = 0; k < 5 * D; k++) begin
            fk = 0;
            for (int i = 0; i < 3; i++) if (f[i] && k >= (i + 2) * D) fk[i] = 1;
            push(c0 + k, 5'b00001 << (k / D), fk, cnt, 0, k == 0 && done0);
        end
        for (int k = 0; k < 5 * D; k++) begin
            if (k == rst_k) begin
                while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
                set_rst(0);
                enable = 1;
                ack = 1;
                push(cyc + 1, 5'b0, 4'b0, 8'd0, 0, 0);
                tick();
                set_rst(1);
                enable = 0;
                ack = 0;
                cnt = 0;
                mode = 0;
                return;
            end
            if (k == drop) enable = 0;
            ack = 1'($urandom);
            tick();
        end
        cnt = cnt + 8'd1;
        if (f != 0) begin
            push(cyc, 5'b11111, f, cnt, 1, 1);
            last_f = f;
            mode = 2;
        end else if (en_after) begin
            mode = 1;
        end else begin
            push(cyc, 5'b0, 4'b0, cnt, 0, 1);
            mode = 0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic random_scans(int n);
        repeat (n) begin
            err_hold = $urandom_range(0, 3);
            scan(pick(100), pick(25), pick(50), pick(35), $urandom_range(0, 3) != 0, -1);
        end
    endtask

    initial begin
        rst0 = 0; rst1 = 0; enable = 1; ack = 1;
        q_cl = 100; q_te = 25; q_fo = 50; q_sa = 35;
        tick();
        push(cyc, 5'b0, 4'b0, 8'd0, 0, 0);
        tick();
        push(cyc, 5'b0, 4'b0, 8'd0, 0, 0);
        rst0 = 1; enable = 0; ack = 0;
        mode = 0;

        err_hold = 10;
        scan(100, 25, 50, 35, 1, -1);
        scan(100, 35, 50, 35, 1, -1);
        err_hold = 2;
        scan(32, 20, 16, 40, 1, -1);
        scan(32, 30, 16, 30, 1, -1);
        scan(100, 19, 50, 35, 1, -1);
        scan(100, 25, 50, 41, 1, -1);
        scan(31, 25, 15, 29, 0, -1);
        random_scans(40);
        repeat (256) scan(100, 25, 50, 35, 1, -1);
        scan(100, 25, 50, 35, 0, -1);
        scan(100, 25, 50, 35, 1, 3 * D + 1);
        scan(100, 25, 50, 35, 0, -1);
        drain();

        dut = 1; D = 1; cnt = 0;
        rst0 = 0; rst1 = 1; enable = 0; ack = 0;
        push(cyc + 1, 5'b0, 4'b0, 8'd0, 0, 0);
        tick();
        mode = 0;
        scan(100, 25, 50, 35, 1, -1);
        scan(100, 25, 50, 35, 1, -1);
        scan(100, 25, 50, 41, 1, -1);
        random_scans(30);
        scan(100, 25, 50, 35, 1, 3);
        scan(100, 31, 50, 35, 0, -1);
        scan(100, 25, 50, 35, 0, -1);
        drain();
        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
